l1_dcache_ctrl: RTL and testbench

- Blocking, direct-mapped, write-back, write-allocate L1 data cache between the MEM-stage load/store path and the memory bus.
- Produces mem_stall, which the hazard unit uses to freeze every pipeline stage until the access completes.
- Hits complete in zero stall cycles. A miss runs an optional dirty-line writeback, then a line refill, as word beats on a req/ready memory interface.

---
 rtl/dcache_pkg.sv | 47 ++++
 rtl/dcache_line_store.sv | 90 +++++++++
 rtl/l1_dcache_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and address-field width helpers for the L1
//                data cache controller and its line store.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Controller states; encoding fixed so waveforms read the same everywhere.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } dcache_state_e;

    // Word-offset bits inside a line.
    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index bits.
    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag bits: whatever is left above byte, word and index fields.
    function automatic int tag_w(input int addr_width, input int num_lines,
                                 input int words_per_line);
        return addr_width - 2 - $clog2(words_per_line) - $clog2(num_lines);
    endfunction

    // Field widths of the default geometry (32-bit address, 16 x 4 words).
    localparam int OFFSET_W = offset_w(4);
    localparam int INDEX_W  = index_w(16);
    localparam int TAG_W    = tag_w(32, 16, 4);

    // Decoded byte address for the default geometry.
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] word;
        logic [1:0]          byte_sel;
    } dcache_addr_t;

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_line_store
//  Description : Register-based valid/dirty/tag/data arrays of a
//                direct-mapped cache. Two combinational word read ports (CPU
//                word and bus beat word) of the addressed line, one byte-masked
//                synchronous word write, and line metadata updates. Only valid
//                and dirty are reset; tags and data are not.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_idx             - line index for every read/write
//                i_cpu_word/o_cpu_data   - CPU word read port
//                i_beat_word/o_beat_data - writeback beat read port
//                o_valid/o_dirty/o_tag   - metadata of line i_idx
//                i_wr_*            - byte-masked data word write
//                i_set_dirty/i_clr_dirty - dirty bit updates
//                i_fill/i_fill_tag - finish a refill: tag, valid=1, dirty=0
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_store #(
    parameter int IDX_W      = 4,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [OFF_W-1:0]        i_cpu_word,
    input  logic [OFF_W-1:0]        i_beat_word,
    output logic                    o_valid,
    output logic                    o_dirty,
    output logic [TAG_W-1:0]        o_tag,
    output logic [DATA_WIDTH-1:0]   o_cpu_data,
    output logic [DATA_WIDTH-1:0]   o_beat_data,
    input  logic                    i_wr_en,
    input  logic [OFF_W-1:0]        i_wr_word,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  logic                    i_set_dirty,
    input  logic                    i_clr_dirty,
    input  logic                    i_fill,
    input  logic [TAG_W-1:0]        i_fill_tag
);

    localparam int c_num_lines = 1 << IDX_W;
    localparam int c_num_words = 1 << (IDX_W + OFF_W);

    logic [c_num_lines-1:0] r_valid;
    logic [c_num_lines-1:0] r_dirty;
    logic [TAG_W-1:0]       r_tag  [c_num_lines];
    logic [DATA_WIDTH-1:0]  r_data [c_num_words];

    assign o_valid     = r_valid[i_idx];
    assign o_dirty     = r_dirty[i_idx];
    assign o_tag       = r_tag[i_idx];
    assign o_cpu_data  = r_data[{i_idx, i_cpu_word}];
    assign o_beat_data = r_data[{i_idx, i_beat_word}];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_idx] <= 1'b1;
        end else if (i_clr_dirty) begin
            r_dirty[i_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag[i_idx] <= i_fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (i_wr_strb[b]) begin
                    r_data[{i_idx, i_wr_word}][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : l1_dcache_ctrl
//  Description : Blocking, direct-mapped, write-back, write-allocate L1 data
//                cache. Hits complete with no stall; a miss writes back a dirty
//                victim (if any), then refills the line word by word over a
//                req/ready bus, after which the held access retries and hits.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                cpu_req/we/addr/wdata/wstrb - MEM-stage load/store
//                cpu_rdata                - full load word (valid when !mem_stall)
//                mem_stall                - freezes the pipeline while high
//                mem_req/we/addr/wdata    - bus beat request (we=1 writeback)
//                mem_rdata/mem_ready      - refill data / beat completion
//                hit_cnt, miss_cnt        - only with DCACHE_PERF_CNT_EN
//  Config      : `define DCACHE_PERF_CNT_EN adds the hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_wstrb,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  mem_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int c_off_w = offset_w(WORDS_PER_LINE);
    localparam int c_idx_w = index_w(NUM_LINES);
    localparam int c_tag_w = tag_w(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);
    localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(WORDS_PER_LINE - 1);

    dcache_state_e        r_state;
    dcache_state_e        w_state_nxt;
    logic [c_off_w-1:0]   r_beat;
    logic [c_off_w-1:0]   w_beat_nxt;

    logic [c_tag_w-1:0]   w_tag;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_off_w-1:0]   w_word;

    logic                 w_line_valid;
    logic                 w_line_dirty;
    logic [c_tag_w-1:0]   w_line_tag;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic                 w_hit;

    logic                 w_wr_en;
    logic [c_off_w-1:0]   w_wr_word;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [3:0]           w_wr_strb;
    logic                 w_set_dirty;
    logic                 w_clr_dirty;
    logic                 w_fill;
    logic                 w_miss_start;

    // The CPU holds its request stable across a stall, so the address fields
    // stay valid for the whole writeback/refill sequence.
    assign w_tag  = cpu_addr[ADDR_WIDTH-1 -: c_tag_w];
    assign w_idx  = cpu_addr[c_off_w+2 +: c_idx_w];
    assign w_word = cpu_addr[2 +: c_off_w];

    assign w_hit     = cpu_req && (r_state == IDLE) && w_line_valid && (w_line_tag == w_tag);
    assign mem_stall = (r_state != IDLE) || (cpu_req && !w_hit);

    dcache_line_store #(
        .IDX_W      (c_idx_w),
        .OFF_W      (c_off_w),
        .TAG_W      (c_tag_w),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_store (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (w_idx),
        .i_cpu_word  (w_word),
        .i_beat_word (r_beat),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_tag       (w_line_tag),
        .o_cpu_data  (cpu_rdata),
        .o_beat_data (w_beat_data),
        .i_wr_en     (w_wr_en),
        .i_wr_word   (w_wr_word),
        .i_wr_data   (w_wr_data),
        .i_wr_strb   (w_wr_strb),
        .i_set_dirty (w_set_dirty),
        .i_clr_dirty (w_clr_dirty),
        .i_fill      (w_fill),
        .i_fill_tag  (w_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_wr_en      = 1'b0;
        w_wr_word    = w_word;
        w_wr_data    = cpu_wdata;
        w_wr_strb    = cpu_wstrb;
        w_set_dirty  = 1'b0;
        w_clr_dirty  = 1'b0;
        w_fill       = 1'b0;
        w_miss_start = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    // Store hit (including a retried store miss): merge the
                    // enabled bytes; dirty is set even with an empty strobe.
                    if (cpu_we) begin
                        w_wr_en     = 1'b1;
                        w_set_dirty = 1'b1;
                    end
                end else if (cpu_req) begin
                    w_miss_start = 1'b1;
                    w_beat_nxt   = '0;
                    w_state_nxt  = (w_line_valid && w_line_dirty) ? WRITEBACK : REFILL;
                end
            end

            WRITEBACK: begin
                // Victim address is rebuilt from the stored (old) tag.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w_line_tag, w_idx, r_beat, 2'b00};
                mem_wdata = w_beat_data;
                if (mem_ready) begin
                    w_beat_nxt = r_beat + 1'b1;
                    if (r_beat == c_last_beat) begin
                        w_clr_dirty = 1'b1;
                        w_state_nxt = REFILL;
                    end
                end
            end

            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_beat, 2'b00};
                if (mem_ready) begin
                    w_wr_en    = 1'b1;
                    w_wr_word  = r_beat;
                    w_wr_data  = mem_rdata;
                    w_wr_strb  = 4'hF;
                    w_beat_nxt = r_beat + 1'b1;
                    if (r_beat == c_last_beat) begin
                        w_fill      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (cpu_req && !mem_stall) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    logic w_unused;
    assign w_unused = ^cpu_addr[1:0];
`else
    // Byte offset only matters downstream; miss pulse only feeds the counters.
    logic w_unused;
    assign w_unused = ^{cpu_addr[1:0], w_miss_start};
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_dcache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_l1_dcache_ctrl
//  Description : Directed self-checking bench for l1_dcache_ctrl. The bus
//                model returns the beat address as refill data and records
//                every accepted beat for comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        mem_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic        rdy_alt  = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] q_addr[$];
    logic        q_we[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    l1_dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .mem_stall (mem_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    // Memory content: each word equals its own address.
    assign mem_rdata = mem_addr;

    // Ready is either always high, or low on the first cycle of each beat
    // (one wait state per beat) while a burst is in progress.
    always @(posedge clk) begin
        #1;
        if (!rdy_alt)
            mem_ready = 1'b1;
        else if (mem_req && prev_req)
            mem_ready = ~mem_ready;
        else
            mem_ready = 1'b0;
        prev_req = mem_req;
    end

    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            q_addr.push_back(mem_addr);
            q_we.push_back(mem_we);
            q_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one access, hold it through the stall, return stall count and
    // the load word seen in the first non-stalled cycle.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             output int stalls, output logic [31:0] rdata);
        int n;
        stalls = 0;
        n      = 0;
        q_addr.delete();
        q_we.delete();
        q_data.delete();
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = strb;
        @(negedge clk);
        while (mem_stall && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (mem_stall) check("access_timeout", {31'd0, mem_stall}, 32'd0);
        rdata = cpu_rdata;
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          st;
        logic [31:0] rd;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        check("idle_stall",    {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #2;

        // Cold load: clean miss, 4 refill beats
        do_access(1'b0, 32'h40, 32'h0, 4'h0, st, rd);
        check("cold_stalls", st, 32'd5);
        check("cold_nbeats", q_addr.size(), 32'd4);
        for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            check("cold_beat_addr", q_addr[i], 32'h40 + 32'(4 * i));
            check("cold_beat_we",   {31'd0, q_we[i]}, 32'd0);
        end
        check("cold_rdata", rd, 32'h40);

        // Hit right after the fill
        do_access(1'b0, 32'h44, 32'h0, 4'h0, st, rd);
        check("hit_stalls", st, 32'd0);
        check("hit_rdata",  rd, 32'h44);
        check("hit_nbeats", q_addr.size(), 32'd0);
        check("hit_mem_req", {31'd0, mem_req}, 32'd0);

        // Partial store then load back
        do_access(1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, st, rd);
        check("store_stalls", st, 32'd0);
        do_access(1'b0, 32'h40, 32'h0, 4'h0, st, rd);
        check("store_merge", rd, 32'h0000BEEF);

        // Conflict miss on a dirty line: writeback then refill
        do_access(1'b0, 32'h440, 32'h0, 4'h0, st, rd);
        check("dirty_stalls", st, 32'd9);
        check("dirty_nbeats", q_addr.size(), 32'd8);
        for (int i = 0; i < q_addr.size() && i < 8; i++) begin
            if (i < 4) begin
                check("wb_addr", q_addr[i], 32'h40 + 32'(4 * i));
                check("wb_we",   {31'd0, q_we[i]}, 32'd1);
            end else begin
                check("rf_addr", q_addr[i], 32'h440 + 32'(4 * (i - 4)));
                check("rf_we",   {31'd0, q_we[i]}, 32'd0);
            end
        end
        if (q_data.size() >= 2) begin
            check("wb_data0", q_data[0], 32'h0000BEEF);
            check("wb_data1", q_data[1], 32'h00000044);
        end
        check("dirty_rdata", rd, 32'h440);

        // Refill with one wait state per beat
        rdy_alt = 1'b1;
        do_access(1'b0, 32'h80, 32'h0, 4'h0, st, rd);
        rdy_alt = 1'b0;
        check("wait_stalls", st, 32'd9);
        check("wait_nbeats", q_addr.size(), 32'd4);
        for (int i = 0; i < q_addr.size() && i < 4; i++)
            check("wait_beat_addr", q_addr[i], 32'h80 + 32'(4 * i));
        check("wait_rdata0", rd, 32'h80);
        do_access(1'b0, 32'h8C, 32'h0, 4'h0, st, rd);
        check("wait_rdata3", rd, 32'h8C);

        // Store with empty strobe still dirties the line
        do_access(1'b1, 32'h8C, 32'hFFFFFFFF, 4'b0000, st, rd);
        do_access(1'b0, 32'h480, 32'h0, 4'h0, st, rd);
        check("zstrb_stalls", st, 32'd9);
        if (q_data.size() >= 4) check("zstrb_wb_data3", q_data[3], 32'h8C);
        check("zstrb_rdata", rd, 32'h480);

        // Reset during the second refill beat
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'hC0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {31'd0, mem_req},   32'd0);
        check("abort_stall",   {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #2;
        do_access(1'b0, 32'hC0, 32'h0, 4'h0, st, rd);
        check("abort_remiss", st, 32'd5);
        check("abort_rdata",  rd, 32'hC0);
        do_access(1'b0, 32'hC4, 32'h0, 4'h0, st, rd);
        do_access(1'b0, 32'hC8, 32'h0, 4'h0, st, rd);
        check("post_hit_rdata", rd, 32'hC8);
`ifdef DCACHE_PERF_CNT_EN
        check("perf_miss_cnt", miss_cnt, 32'd1);
        check("perf_hit_cnt",  hit_cnt,  32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
